// File: rtl/hack_alu_pkg.sv
// Shared definitions for the pipelined Hack ALU: control bit layout and
// the named Hack comp encodings used by decode and by test code.
package hack_alu_pkg;

  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

  localparam logic [5:0] ALU_ZERO      = 6'b101010;
  localparam logic [5:0] ALU_ONE       = 6'b111111;
  localparam logic [5:0] ALU_X         = 6'b001100;
  localparam logic [5:0] ALU_X_PLUS_Y  = 6'b000010;
  localparam logic [5:0] ALU_X_MINUS_Y = 6'b010011;
  localparam logic [5:0] ALU_X_AND_Y   = 6'b000000;

  function automatic ctrl_t decode_ctrl(input logic [5:0] c);
    ctrl_t d;
    d.zx = c[CTRL_ZX];
    d.nx = c[CTRL_NX];
    d.zy = c[CTRL_ZY];
    d.ny = c[CTRL_NY];
    d.f  = c[CTRL_F];
    d.no = c[CTRL_NO];
    return d;
  endfunction

endpackage

// File: rtl/hack_alu_pipe_if.sv
// Operand-side and result-side handshake bundle of the pipelined Hack ALU.
// master = producer/consumer environment, slave = the ALU itself.
interface hack_alu_pipe_if #(parameter int WIDTH = 16);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] y;
  logic        [5:0]       ctrl;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out;
  logic                    zr;
  logic                    ng;
  logic                    cy;
  logic                    ov;

  modport master (
    output in_valid, x, y, ctrl, out_ready,
    input  in_ready, out_valid, out, zr, ng, cy, ov
  );

  modport slave (
    input  in_valid, x, y, ctrl, out_ready,
    output in_ready, out_valid, out, zr, ng, cy, ov
  );

endinterface

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU back half: add/and of already-preset operands,
// optional output inversion, and zero/negative/carry/overflow flags.
module hack_alu_core
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic                    f,
  input  logic                    no,
  output logic signed [WIDTH-1:0] out,
  output logic                    zr,
  output logic                    ng,
  output logic                    cy,
  output logic                    ov
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
  function automatic logic signed_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    r   = f ? sum[WIDTH-1:0] : (x & y);
    out = no ? ~r : r;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
    // Carry and overflow describe the adder itself, so they ignore 'no'.
    cy  = f & sum[WIDTH];
    ov  = f & signed_ovf(x[WIDTH-1], y[WIDTH-1], sum[WIDTH-1]);
  end

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage valid/ready pipelined Hack ALU: stage 1 presets operands,
// stage 2 registers the core result and flags; counts delivered results.
module hack_alu_pipe
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  hack_alu_pipe_if.slave   bus,
  output logic [CNT_W-1:0] op_count
);

  ctrl_t                   c_in;
  logic                    load_p1;
  logic                    load_p2;
  logic                    in_ready;
  logic                    accept;
  logic signed [WIDTH-1:0] x_pre;
  logic signed [WIDTH-1:0] y_pre;

  logic                    vld_p1;
  logic signed [WIDTH-1:0] x_p1;
  logic signed [WIDTH-1:0] y_p1;
  logic                    f_p1;
  logic                    no_p1;

  logic signed [WIDTH-1:0] out_c;
  logic                    zr_c, ng_c, cy_c, ov_c;

  logic                    vld_p2;
  logic signed [WIDTH-1:0] out_p2;
  logic                    zr_p2, ng_p2, cy_p2, ov_p2;

  assign c_in    = decode_ctrl(bus.ctrl);
  assign load_p2 = !vld_p2 || bus.out_ready;
  assign load_p1 = !vld_p1 || load_p2;
  assign in_ready = reset_n && load_p1 && !flush;
  assign accept  = bus.in_valid && in_ready;

  always_comb begin
    x_pre = c_in.zx ? '0 : bus.x;
    if (c_in.nx) x_pre = ~x_pre;
    y_pre = c_in.zy ? '0 : bus.y;
    if (c_in.ny) y_pre = ~y_pre;
  end

  // ---- stage 1: preset operands and f/no ----
  always_ff @(posedge clock) begin
    if (accept) begin
      x_p1  <= x_pre;
      y_p1  <= y_pre;
      f_p1  <= c_in.f;
      no_p1 <= c_in.no;
    end
  end

  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x   (x_p1),
    .y   (y_p1),
    .f   (f_p1),
    .no  (no_p1),
    .out (out_c),
    .zr  (zr_c),
    .ng  (ng_c),
    .cy  (cy_c),
    .ov  (ov_c)
  );

  // ---- stage 2: registered result and flags ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_p2 <= '0;
      zr_p2  <= 1'b0;
      ng_p2  <= 1'b0;
      cy_p2  <= 1'b0;
      ov_p2  <= 1'b0;
    end else if (load_p2 && vld_p1) begin
      out_p2 <= out_c;
      zr_p2  <= zr_c;
      ng_p2  <= ng_c;
      cy_p2  <= cy_c;
      ov_p2  <= ov_c;
    end
  end

  // A transfer coinciding with flush still counts: the consumer took it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      op_count <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        if (load_p1) vld_p1 <= accept;
        if (load_p2) vld_p2 <= vld_p1;
      end
      if (vld_p2 && bus.out_ready) op_count <= op_count + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2;
  assign bus.out       = out_p2;
  assign bus.zr        = zr_p2;
  assign bus.ng        = ng_p2;
  assign bus.cy        = cy_p2;
  assign bus.ov        = ov_p2;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed bench for hack_alu_pipe at WIDTH=16 and WIDTH=8 with a
// scoreboard of model-predicted results per instance.
module tb_hack_alu_pipe;
  import hack_alu_pkg::*;

  typedef struct packed {
    logic [15:0] o;
    logic        zr;
    logic        ng;
    logic        cy;
    logic        ov;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        flush8;
  logic [15:0] cnt16;
  logic [7:0]  cnt8;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        sb8[$];
  exp_t        held;

  hack_alu_pipe_if #(.WIDTH(16)) b16 ();
  hack_alu_pipe_if #(.WIDTH(8))  b8 ();

  hack_alu_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .bus      (b16),
    .op_count (cnt16)
  );

  hack_alu_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush8),
    .bus      (b8),
    .op_count (cnt8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int w, input logic [5:0] c, input int xi, input int yi);
    longint mask, half, xa, ya, sx, sy, us, ss, r, o;
    exp_t   e;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    xa = longint'(xi) & mask;
    ya = longint'(yi) & mask;
    if (c[5]) xa = 0;
    if (c[4]) xa = ~xa & mask;
    if (c[3]) ya = 0;
    if (c[2]) ya = ~ya & mask;
    sx = (xa >= half) ? xa - (mask + 1) : xa;
    sy = (ya >= half) ? ya - (mask + 1) : ya;
    us = xa + ya;
    ss = sx + sy;
    r  = c[1] ? (us & mask) : (xa & ya);
    o  = c[0] ? (~r & mask) : r;
    e.o  = o[15:0];
    e.zr = (o == 0);
    e.ng = ((o >> (w - 1)) & 1) != 0;
    e.cy = c[1] && ((us >> w) != 0);
    e.ov = c[1] && ((ss > half - 1) || (ss < -half));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send16(input logic [5:0] c, input int xi, input int yi);
    bit got = 1'b0;
    b16.in_valid = 1'b1;
    b16.ctrl     = c;
    b16.x        = 16'(xi);
    b16.y        = 16'(yi);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = b16.in_ready;
      @(posedge clock);
      #1;
    end
    if (got) sb.push_back(model(16, c, xi, yi));
    else chk("send16_timeout", 32'(got), 1);
    b16.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [5:0] c, input int xi, input int yi);
    bit got = 1'b0;
    b8.in_valid = 1'b1;
    b8.ctrl     = c;
    b8.x        = 8'(xi);
    b8.y        = 8'(yi);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = b8.in_ready;
      @(posedge clock);
      #1;
    end
    if (got) sb8.push_back(model(8, c, xi, yi));
    else chk("send8_timeout", 32'(got), 1);
    b8.in_valid = 1'b0;
  endtask

  // Results are taken at the negedge before the edge that transfers them.
  always @(negedge clock) begin
    if (reset_n && b16.out_valid && b16.out_ready) begin
      chk("sb16_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) chk("out16", {b16.out, b16.zr, b16.ng, b16.cy, b16.ov}, sb.pop_front());
    end
  end

  always @(negedge clock) begin
    if (reset_n && b8.out_valid && b8.out_ready) begin
      chk("sb8_pending", 32'(sb8.size() > 0), 1);
      if (sb8.size() > 0) chk("out8", {8'h00, b8.out, b8.zr, b8.ng, b8.cy, b8.ov}, sb8.pop_front());
    end
  end

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    flush8       = 1'b0;
    b16.in_valid = 1'b0;
    b16.out_ready = 1'b1;
    b16.x        = '0;
    b16.y        = '0;
    b16.ctrl     = '0;
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    b8.x         = '0;
    b8.y         = '0;
    b8.ctrl      = '0;

    repeat (2) @(negedge clock);
    chk("rst_in_ready", 32'(b16.in_ready), 0);
    chk("rst_out_valid", 32'(b16.out_valid), 0);
    chk("rst_out_flags", {b16.out, b16.zr, b16.ng, b16.cy, b16.ov}, 0);
    chk("rst_count", 32'(cnt16), 0);
    chk("rst8_in_ready", 32'(b8.in_ready), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    send16(ALU_X_PLUS_Y, 9, 15);
    chk("lat_stage1_only", 32'(b16.out_valid), 0);
    @(posedge clock);
    #1;
    chk("lat_valid_n_plus_1", 32'(b16.out_valid), 1);

    send16(ALU_X_MINUS_Y, 9, 15);
    send16(ALU_ZERO, 9, 15);
    send16(ALU_ONE, 9, 15);
    send16(ALU_X_PLUS_Y, 32767, 1);
    send16(ALU_X_PLUS_Y, -1, 1);
    send16(ALU_X_AND_Y, 16'hF0F0, 16'h3CC3);
    send16(ALU_X, -5, 7);
    repeat (4) @(posedge clock);
    #1;
    chk("count_after_stream", 32'(cnt16), 8);

    send8(ALU_X_PLUS_Y, 127, 1);
    send8(ALU_X_AND_Y, 'hF0, 'h3C);
    send8(ALU_X_MINUS_Y, 3, 100);
    repeat (4) @(posedge clock);
    #1;
    chk("count8_after_stream", 32'(cnt8), 3);

    b16.out_ready = 1'b0;
    send16(ALU_X_PLUS_Y, 100, 200);
    send16(ALU_X_MINUS_Y, 100, 200);
    b16.in_valid = 1'b1;
    b16.ctrl     = ALU_X_AND_Y;
    b16.x        = 16'h0FF0;
    b16.y        = 16'h00FF;
    held = sb[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready_low", 32'(b16.in_ready), 0);
      chk("bp_out_valid", 32'(b16.out_valid), 1);
      chk("bp_out_hold", {b16.out, b16.zr, b16.ng, b16.cy, b16.ov}, held);
      @(posedge clock);
      #1;
    end
    b16.out_ready = 1'b1;
    @(negedge clock);
    chk("bp_accept_on_release", 32'(b16.in_ready), 1);
    sb.push_back(model(16, ALU_X_AND_Y, 'h0FF0, 'h00FF));
    @(posedge clock);
    #1;
    b16.in_valid = 1'b0;
    send16(ALU_X_PLUS_Y, -300, -400);
    repeat (5) @(posedge clock);
    #1;
    chk("bp_count", 32'(cnt16), 12);
    chk("bp_drained", 32'(sb.size()), 0);

    b16.out_ready = 1'b0;
    send16(ALU_X_PLUS_Y, 1, 2);
    send16(ALU_X_PLUS_Y, 3, 4);
    b16.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", 32'(b16.in_ready), 0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    b16.in_valid = 1'b0;
    chk("flush_out_valid", 32'(b16.out_valid), 0);
    chk("flush_count", 32'(cnt16), 12);
    sb.delete();
    b16.out_ready = 1'b1;
    @(negedge clock);
    chk("flush_ready_after", 32'(b16.in_ready), 1);
    @(posedge clock);
    #1;
    chk("flush_no_ghost", 32'(b16.out_valid), 0);

    send16(ALU_X_PLUS_Y, 7, 8);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_xfer_counted", 32'(cnt16), 13);
    chk("flush_xfer_valid", 32'(b16.out_valid), 0);

    send16(ALU_X_PLUS_Y, 5, 3);
    send16(ALU_X_PLUS_Y, 6, 3);
    chk("pre_reset_valid", 32'(b16.out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(b16.out_valid), 0);
    chk("async_rst_out", {b16.out, b16.zr, b16.ng, b16.cy, b16.ov}, 0);
    chk("async_rst_count", 32'(cnt16), 0);
    chk("async_rst_in_ready", 32'(b16.in_ready), 0);
    chk("async_rst_count8", 32'(cnt8), 0);
    sb.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_reset_idle", 32'(b16.out_valid), 0);
    chk("sb8_empty", 32'(sb8.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
